// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM state
// encoding, default RAM word-address width and request legality helpers.
package load_store_unit_pkg;

    localparam int LSU_AWIDTH = 10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_DATA = 2'd3
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                     (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    // Offset not a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_gen.sv
// Combinational lane/shift generator: byte enables, store-data shift and the
// word-spanning flag for either half of an access.
module lsu_lane_gen
    import load_store_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] off,
    input  logic       half,
    output logic [3:0] be,
    output logic [5:0] shamt,
    output logic       spans
);

    logic [3:0] size_mask;
    logic [7:0] span_mask;
    logic       unused_sign;

    assign unused_sign = funct3[2];

    always_comb begin
        case (funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Lanes of the first word sit in the low nibble, overflow into the next word in the high nibble.
    assign span_mask = {4'b0000, size_mask} << off;
    assign be        = half ? span_mask[7:4] : span_mask[3:0];
    assign shamt     = half ? (6'd32 - {1'b0, off, 3'b000}) : {1'b0, off, 3'b000};
    assign spans     = |span_mask[7:4];

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed B/H/W requests into word RAM accesses.
// Build option MISALIGN_SPLIT_EN: word-spanning accesses become two RAM cycles.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int AWIDTH = LSU_AWIDTH,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] ext;
        case (f3[1:0])
            2'b00:   ext = {{24{raw[7] & ~f3[2]}}, raw[7:0]};
            2'b01:   ext = {{16{raw[15] & ~f3[2]}}, raw[15:0]};
            default: ext = raw;
        endcase
        return ext;
    endfunction

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic              idle;
    logic [2:0]        lg_funct3;
    logic [1:0]        lg_off;
    logic [3:0]        lg_be;
    logic [5:0]        lg_shamt;
    logic              lg_spans;
    logic              req_err;
    logic [DWIDTH-1:0] load_raw;
    logic              unused_addr;

    assign unused_addr = ^req_addr[31:AWIDTH+2];

    // In IDLE the generator looks at the incoming request; otherwise at the latched one (second half).
    assign idle      = (state_q == ST_IDLE);
    assign lg_funct3 = idle ? req_funct3 : f3_q;
    assign lg_off    = idle ? req_addr[1:0] : off_q;

    lsu_lane_gen u_lane_gen (
        .funct3 (lg_funct3),
        .off    (lg_off),
        .half   (~idle),
        .be     (lg_be),
        .shamt  (lg_shamt),
        .spans  (lg_spans)
    );

`ifdef MISALIGN_SPLIT_EN
    logic [DWIDTH-1:0]   lo_q, lo_d;
    logic [2*DWIDTH-1:0] pair, pair_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lo_q <= '0;
        else        lo_q <= lo_d;
    end

    always_comb begin
        pair     = lg_spans ? {mem_rdata, lo_q} : {{DWIDTH{1'b0}}, mem_rdata};
        pair_sh  = pair >> {off_q, 3'b000};
        load_raw = pair_sh[DWIDTH-1:0];
    end

    assign req_err = ~f3_legal(req_we, req_funct3);
`else
    logic unused_spans;
    assign unused_spans = lg_spans;
    assign load_raw     = mem_rdata >> {off_q, 3'b000};
    assign req_err      = ~f3_legal(req_we, req_funct3) | is_misaligned(req_funct3, req_addr[1:0]);
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = 4'b0000;
        mem_wdata_d = mem_wdata_q;
`ifdef MISALIGN_SPLIT_EN
        lo_d        = lo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d     = ST_ACC0;
                        mem_addr_d  = req_addr[AWIDTH+1:2];
                        mem_be_d    = req_we ? lg_be : 4'b0000;
                        mem_wdata_d = req_wdata << lg_shamt;
                    end
                end
            end
            ST_ACC0: begin
`ifdef MISALIGN_SPLIT_EN
                if (lg_spans) begin
                    state_d     = ST_ACC1;
                    mem_addr_d  = mem_addr_q + 1'b1;
                    mem_be_d    = we_q ? lg_be : 4'b0000;
                    mem_wdata_d = wdata_q >> lg_shamt;
                end else begin
                    state_d = ST_DATA;
                end
`else
                state_d = ST_DATA;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            ST_ACC1: begin
                lo_d    = mem_rdata;
                state_d = ST_DATA;
            end
`endif
            ST_DATA: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_rdata_d = (err_q | we_q) ? '0 : load_extend(f3_q, load_raw);
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
